// File: rtl/smp_fetch_pkg.sv
// Shared fetch-stage types and constants, also used by decode and the hazard unit.
package smp_fetch_pkg;

  localparam int ADDR_W     = 13;
  localparam int INSTR_W    = 20;
  localparam int OPCODE_MSB = 19;
  localparam int OPCODE_LSB = 15;
  localparam int OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;
  localparam int CNT_W      = 16;

  localparam logic [INSTR_W-1:0]  NOP_INSTR_DEF = 20'h00000;
  localparam logic [OPCODE_W-1:0] HALT_OP_DEF   = 5'h1F;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  function automatic logic [OPCODE_W-1:0] get_opcode(input logic [INSTR_W-1:0] instr);
    return instr[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/instr_fetch_pc_gen.sv
// Program counter: redirect / hold / increment with natural 13-bit wrap.
module pc_gen
  import smp_fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 13'h0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect_i,
  input  logic              hold_i,
  input  logic [ADDR_W-1:0] dst_i,
  output logic [ADDR_W-1:0] pc_o
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  // Next-PC select; redirect outranks hold, increment wraps 8191 -> 0.
  always_comb begin
    pc_d = pc_q;
    if (redirect_i) begin
      pc_d = dst_i;
    end else if (hold_i) begin
      pc_d = pc_q;
    end else begin
      pc_d = pc_q + 13'd1;
    end
  end

  // PC register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: drives imem address from the PC and captures the returned word into IF/ID.
module instr_fetch
  import smp_fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0]   RESET_PC  = 13'h0000,
  parameter logic [OPCODE_W-1:0] HALT_OP   = HALT_OP_DEF,
  parameter logic [INSTR_W-1:0]  NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall_IF_ID,
  input  logic               flow_change_ID_EX,
  input  logic [ADDR_W-1:0]  dst_ID_EX,
  input  logic [INSTR_W-1:0] instr_in,
  output logic [ADDR_W-1:0]  iaddr,
  output logic [INSTR_W-1:0] instr_IF_ID,
  output logic [ADDR_W-1:0]  pc_IF_ID,
  output logic               valid_IF_ID,
  output logic               halted,
  output logic [CNT_W-1:0]   fetch_cnt
);

  fetch_state_t       state_q, state_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  pcid_q, pcid_d;
  logic               valid_q, valid_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pc_redirect_s;
  logic               pc_hold_s;
  logic [ADDR_W-1:0]  pc_s;

  pc_gen #(
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .redirect_i (pc_redirect_s),
    .hold_i     (pc_hold_s),
    .dst_i      (dst_ID_EX),
    .pc_o       (pc_s)
  );

  // FSM next state, IF/ID next values and PC control.
  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    pcid_d        = pcid_q;
    valid_d       = valid_q;
    cnt_d         = cnt_q;
    pc_redirect_s = 1'b0;
    pc_hold_s     = 1'b1;
    if (flow_change_ID_EX) begin
      // Redirect squashes whatever is in flight, including a halt word.
      pc_redirect_s = 1'b1;
      instr_d       = NOP_INSTR;
      valid_d       = 1'b0;
      state_d       = RUN;
    end else if (stall_IF_ID) begin
      pc_hold_s = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          instr_d = instr_in;
          pcid_d  = pc_s + 13'd1;
          valid_d = 1'b1;
          cnt_d   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
          if (get_opcode(instr_in) == HALT_OP) begin
            state_d   = HALT;
            pc_hold_s = 1'b1;
          end else begin
            pc_hold_s = 1'b0;
          end
        end
        HALT: begin
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
        end
        default: begin
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
          state_d = RUN;
        end
      endcase
    end
  end

  // FSM state, IF/ID pipeline register and fetch counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      instr_q <= NOP_INSTR;
      pcid_q  <= 13'd0;
      valid_q <= 1'b0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      pcid_q  <= pcid_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign iaddr       = pc_s;
  assign instr_IF_ID = instr_q;
  assign pc_IF_ID    = pcid_q;
  assign valid_IF_ID = valid_q;
  assign halted      = (state_q == HALT);
  assign fetch_cnt   = cnt_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: a behavioural fetch model pushes expectations per cycle.
module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic        stall_IF_ID;
  logic        flow_change_ID_EX;
  logic [12:0] dst_ID_EX;
  logic [19:0] instr_in;
  logic [12:0] iaddr;
  logic [19:0] instr_IF_ID;
  logic [12:0] pc_IF_ID;
  logic        valid_IF_ID;
  logic        halted;
  logic [15:0] fetch_cnt;

  logic [19:0] mem [0:8191];

  typedef struct {
    logic [12:0] iaddr;
    logic [19:0] instr;
    logic [12:0] pcid;
    logic        valid;
    logic        halted;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb_q[$];

  logic [12:0] m_pc;
  logic        m_halt;
  logic [19:0] m_instr;
  logic [12:0] m_pcid;
  logic        m_valid;
  logic [15:0] m_cnt;

  int n_checks;
  int n_pass;

  instr_fetch dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .stall_IF_ID       (stall_IF_ID),
    .flow_change_ID_EX (flow_change_ID_EX),
    .dst_ID_EX         (dst_ID_EX),
    .instr_in          (instr_in),
    .iaddr             (iaddr),
    .instr_IF_ID       (instr_IF_ID),
    .pc_IF_ID          (pc_IF_ID),
    .valid_IF_ID       (valid_IF_ID),
    .halted            (halted),
    .fetch_cnt         (fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory latches its output on the falling edge.
  always @(negedge clk) instr_in <= mem[iaddr];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc    = 13'h0000;
    m_halt  = 1'b0;
    m_instr = 20'h00000;
    m_pcid  = 13'd0;
    m_valid = 1'b0;
    m_cnt   = 16'd0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, ".iaddr"},  32'(iaddr),       32'h0);
    check_val({tag, ".instr"},  32'(instr_IF_ID), 32'h0);
    check_val({tag, ".pcid"},   32'(pc_IF_ID),    32'h0);
    check_val({tag, ".valid"},  32'(valid_IF_ID), 32'h0);
    check_val({tag, ".halted"}, 32'(halted),      32'h0);
    check_val({tag, ".cnt"},    32'(fetch_cnt),   32'h0);
  endtask

  task automatic step(input string tag, input logic st, input logic fc, input logic [12:0] dst);
    exp_t e;
    exp_t got;
    @(negedge clk);
    #1;
    stall_IF_ID       = st;
    flow_change_ID_EX = fc;
    dst_ID_EX         = dst;
    if (fc) begin
      m_pc    = dst;
      m_instr = 20'h00000;
      m_valid = 1'b0;
      m_halt  = 1'b0;
    end else if (st) begin
      m_pc = m_pc;
    end else if (!m_halt) begin
      m_instr = mem[m_pc];
      m_pcid  = m_pc + 13'd1;
      m_valid = 1'b1;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      if (mem[m_pc][19:15] == 5'h1F) m_halt = 1'b1;
      else m_pc = m_pc + 13'd1;
    end else begin
      m_instr = 20'h00000;
      m_valid = 1'b0;
    end
    e.iaddr  = m_pc;
    e.instr  = m_instr;
    e.pcid   = m_pcid;
    e.valid  = m_valid;
    e.halted = m_halt;
    e.cnt    = m_cnt;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    check_val({tag, ".iaddr"},  32'(iaddr),       32'(got.iaddr));
    check_val({tag, ".instr"},  32'(instr_IF_ID), 32'(got.instr));
    check_val({tag, ".valid"},  32'(valid_IF_ID), 32'(got.valid));
    check_val({tag, ".halted"}, 32'(halted),      32'(got.halted));
    check_val({tag, ".cnt"},    32'(fetch_cnt),   32'(got.cnt));
    if (got.valid) check_val({tag, ".pcid"}, 32'(pc_IF_ID), 32'(got.pcid));
  endtask

  initial begin
    n_checks          = 0;
    n_pass            = 0;
    rst_n             = 1'b0;
    stall_IF_ID       = 1'b0;
    flow_change_ID_EX = 1'b0;
    dst_ID_EX         = 13'd0;
    for (int i = 0; i < 8192; i++) mem[i] = 20'h00000;
    mem[0]      = 20'h01000;
    mem[1]      = 20'h02000;
    mem[2]      = 20'h03000;
    mem[3]      = 20'h04000;
    mem[4]      = 20'h05000;
    mem[5]      = 20'h06000;
    mem[6]      = 20'h07000;
    mem[7]      = 20'h08000;
    mem[13'h20] = 20'h0C0DE;
    mem[13'h100] = 20'h0ABCD;
    mem[13'h1FFF] = 20'h07777;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) step("seq", 1'b0, 1'b0, 13'd0);
    for (int i = 0; i < 3; i++) step("stall", 1'b1, 1'b0, 13'd0);
    for (int i = 0; i < 2; i++) step("resume", 1'b0, 1'b0, 13'd0);
    step("flush_stall", 1'b1, 1'b1, 13'h100);
    step("after_flush", 1'b0, 1'b0, 13'd0);
    step("to_top", 1'b0, 1'b1, 13'h1FFF);
    step("wrap", 1'b0, 1'b0, 13'd0);
    step("to_2", 1'b0, 1'b1, 13'd2);
    step("fetch2", 1'b0, 1'b0, 13'd0);
    mem[4] = 20'hF8000;
    step("fetch3", 1'b0, 1'b0, 13'd0);
    step("halt_squash", 1'b0, 1'b1, 13'd4);
    step("halt_enter", 1'b0, 1'b0, 13'd0);
    step("halt_nop", 1'b0, 1'b0, 13'd0);
    step("halt_nop2", 1'b0, 1'b0, 13'd0);
    step("halt_stall", 1'b1, 1'b0, 13'd0);
    check_val("cnt_before_rst", 32'(fetch_cnt), 32'd12);

    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    step("re_to_4", 1'b0, 1'b1, 13'd4);
    step("re_halt", 1'b0, 1'b0, 13'd0);
    step("halt_exit", 1'b0, 1'b1, 13'h20);
    step("at_20", 1'b0, 1'b0, 13'd0);
    step("at_21", 1'b0, 1'b0, 13'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
